// File: rtl/blake_pkg.sv
// Shared BLAKE-512 constants and word-slice helpers used by the round core
// and the finalisation stage.
package blake_pkg;

    localparam logic [63:0] IV0 = 64'h6A09E667F3BCC908;
    localparam logic [63:0] IV1 = 64'hBB67AE8584CAA73B;
    localparam logic [63:0] IV2 = 64'h3C6EF372FE94F82B;
    localparam logic [63:0] IV3 = 64'hA54FF53A5F1D36F1;
    localparam logic [63:0] IV4 = 64'h510E527FADE682D1;
    localparam logic [63:0] IV5 = 64'h9B05688C2B3E6C1F;
    localparam logic [63:0] IV6 = 64'h1F83D9ABFB41BD6B;
    localparam logic [63:0] IV7 = 64'h5BE0CD19137E2179;

    localparam logic [511:0] IV = {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};

    localparam logic [63:0] CB0  = 64'h243F6A8885A308D3;
    localparam logic [63:0] CB1  = 64'h13198A2E03707344;
    localparam logic [63:0] CB2  = 64'hA4093822299F31D0;
    localparam logic [63:0] CB3  = 64'h082EFA98EC4E6C89;
    localparam logic [63:0] CB4  = 64'h452821E638D01377;
    localparam logic [63:0] CB5  = 64'hBE5466CF34E90C6C;
    localparam logic [63:0] CB6  = 64'hC0AC29B7C97C50DD;
    localparam logic [63:0] CB7  = 64'h3F84D5B5B5470917;
    localparam logic [63:0] CB8  = 64'h9216D5D98979FB1B;
    localparam logic [63:0] CB9  = 64'hD1310BA698DFB5AC;
    localparam logic [63:0] CB10 = 64'h2FFD72DBD01ADFB7;
    localparam logic [63:0] CB11 = 64'hB8E1AFED6A267E96;
    localparam logic [63:0] CB12 = 64'hBA7C9045F12C7F99;
    localparam logic [63:0] CB13 = 64'h24A19947B3916CF7;
    localparam logic [63:0] CB14 = 64'h0801F2E2858EFC16;
    localparam logic [63:0] CB15 = 64'h636920D871574E69;

    // Single 640-bit block: counter low word is 640, high word zero, salt zero.
    localparam logic [63:0] T0 = 64'd640;
    localparam logic [63:0] T1 = 64'd0;

    localparam logic [1023:0] V_INIT = {IV, CB0, CB1, CB2, CB3,
                                        CB4 ^ T0, CB5 ^ T0, CB6 ^ T1, CB7 ^ T1};

    // Word 0 sits in the most significant slice, so the LSB is (N-1-idx)*64.
    function automatic logic [9:0] v_lsb(input logic [3:0] idx);
        return {~idx, 6'b0};
    endfunction

    function automatic logic [8:0] h_lsb(input logic [2:0] idx);
        return {~idx, 6'b0};
    endfunction

    function automatic logic [63:0] v_word(input logic [1023:0] v, input logic [3:0] idx);
        return v[v_lsb(idx) +: 64];
    endfunction

endpackage

// File: rtl/blake_out_hold.sv
// Single-entry valid/ready hold register; a new item is dropped (and the
// sticky overrun raised) when the register is full and not being drained.
module blake_out_hold
    import blake_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun,
    output logic         accept
);

    logic drop;

    assign accept = load_valid && (!valid || ready);
    assign drop   = load_valid && valid && !ready;

    // A load wins over a drain, so a simultaneous drain+load keeps valid high.
    always_ff @(posedge clk) begin
        if (rstb) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/blake_finalize.sv
// BLAKE-512 finalisation: folds the 1024-bit working state into the chain
// value, compares it against a target and presents it behind valid/ready.
module blake_finalize
    import blake_pkg::*;
#(
    parameter int CMP_W = 64,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              count_done,
    input  logic [1023:0]     v_in,
    input  logic [CMP_W-1:0]  target,
    input  logic              hash_ready,
    output logic [511:0]      hash_out,
    output logic              hash_valid,
    output logic              hit,
    output logic              overrun,
    output logic [CNT_W-1:0]  result_cnt
);

    logic [511:0] fold;
    logic [511:0] fold_q;
    logic         s1_valid;
    logic [511:0] cand;
    logic         cand_hit;
    logic [511:0] cand_q;
    logic         cand_hit_q;
    logic         s2_valid;
    logic [512:0] held;
    logic         accept;

    always_comb begin
        fold = '0;
        for (int i = 0; i < 8; i++) begin
            fold[h_lsb(3'(i)) +: 64] = v_word(v_in, 4'(i)) ^ v_word(v_in, 4'(i + 8));
        end
    end

    // The chain input is IV because this is the first and only block.
    assign cand     = IV ^ fold_q;
    assign cand_hit = (cand[CMP_W-1:0] <= target);

    always_ff @(posedge clk) begin
        if (rstb) begin
            s1_valid   <= 1'b0;
            fold_q     <= '0;
            s2_valid   <= 1'b0;
            cand_q     <= '0;
            cand_hit_q <= 1'b0;
        end else begin
            s1_valid <= count_done;
            if (count_done) begin
                fold_q <= fold;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                cand_q     <= cand;
                cand_hit_q <= cand_hit;
            end
        end
    end

    blake_out_hold #(
        .W (513)
    ) u_hold (
        .clk        (clk),
        .rstb       (rstb),
        .load_valid (s2_valid),
        .load_data  ({cand_hit_q, cand_q}),
        .ready      (hash_ready),
        .data       (held),
        .valid      (hash_valid),
        .overrun    (overrun),
        .accept     (accept)
    );

    assign hit      = held[512];
    assign hash_out = held[511:0];

    always_ff @(posedge clk) begin
        if (rstb) begin
            result_cnt <= '0;
        end else if (accept) begin
            result_cnt <= result_cnt + 1'b1;
        end
    end

endmodule

// File: doc/blake_finalize.md
Name: blake_finalize

Overview:
- Downstream stage of the BLAKE-512 round core. Consumes the 1024-bit working state `v` when the round counter signals completion.
- Folds the state into the 512-bit chain value: h'[i] = IV[i] ^ v[i] ^ v[i+8]. Salt is zero and the chain input is IV, because this is a single-block 640-bit-counter message.
- Holds the result behind a valid/ready handshake, flags a target hit, counts results and flags overruns.

Parameters:
- CMP_W, 64: number of low bits of hash_out compared against target (1..512).
- CNT_W, 16: width of the result counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstb  in  1  reset; synchronous, active-high.
- count_done  in  1  one-cycle pulse: v_in holds the final state this cycle.
- v_in  in  1024  working state; v0 = [1023:960] … v15 = [63:0].
- target  in  CMP_W  compare threshold; sampled in stage 2.
- hash_ready  in  1  consumer accepts hash_out when high with hash_valid.
- hash_out  out  512  h'0 = [511:448] … h'7 = [63:0].
- hash_valid  out  1  result held and valid.
- hit  out  1  hash_out[CMP_W-1:0] <= target, unsigned; qualified by hash_valid.
- overrun  out  1  sticky: a result was dropped.
- result_cnt  out  CNT_W  number of results accepted into the hold register; wraps.

Behaviour:
- Reset (rstb=1 at edge): hash_out=0, hash_valid=0, hit=0, overrun=0, result_cnt=0, all stage valids=0. In-flight results are discarded.
- Stage 1 (edge where count_done=1):
  - fold_q[i] <= v[i] ^ v[i+8] for i=0..7.
  - s1_valid <= 1, otherwise 0.
  - No backpressure: the stage always advances.
- Stage 2 (edge where s1_valid=1): computes cand = IV ^ fold_q and cand_hit = (cand[CMP_W-1:0] <= target).
- Hold-register load (the stage-2 result is loaded when the register is empty or being drained):
  - If !hash_valid, or hash_valid && hash_ready: hash_out <= cand, hit <= cand_hit, hash_valid <= 1, result_cnt += 1 (modulo 2^CNT_W).
  - Else: cand is dropped, overrun <= 1; hash_out, hit and result_cnt are unchanged.
- Drain: hash_valid && hash_ready with no stage-2 result that cycle gives hash_valid <= 0. hash_out and hit keep their last values.
- Latency: count_done at edge N gives hash_valid=1 after edge N+2, provided the hold register is free.
- Throughput: one result per cycle. Back-to-back count_done pulses are legal.
- Simultaneous drain and load in the same cycle: the new result replaces the old one, hash_valid stays 1, no overrun.
- hash_out, hit and hash_valid never change while hash_valid && !hash_ready, except on reset.
- overrun clears only on reset.
- A count_done in the same cycle as rstb=1 is ignored.

Decomposition:
- Package blake_pkg holds:
  - the IV0..IV7 constants (6A09E667F3BCC908 … 5BE0CD19137E2179);
  - the constants CB0..CB15 and the v-init vector shared with the state register;
  - the word-slice helpers (word index → bit range).
- One sub-module, blake_out_hold: the valid/ready hold register, parameterised on data width. It provides load/accept, drop and overrun detection.
- Stage 1 and stage 2 are inline in blake_finalize.

Test Plan:
- Zero state: v_in=0, count_done pulse, hash_ready=1 → 2 cycles later hash_valid=1, hash_out = IV (h'0=6A09E667F3BCC908, h'7=5BE0CD19137E2179), result_cnt=1.
- Fold check: v0=0000000000000001, v8=FFFFFFFFFFFFFFFF, rest 0 → h'0 = 95F61998 0C4336F6; h'1..h'7 = IV.
- Target compare with v_in=0, CMP_W=64: target=5BE0CD19137E2179 → hit=1; target=5BE0CD19137E2178 → hit=0.
- Backpressure: hash_ready=0, count_done pulses at cycles 0 and 3 → first result held and unchanged, overrun=1 from cycle 5, result_cnt=1. Raise hash_ready → hash_valid drops the next cycle.
- Back-to-back: three count_done pulses on consecutive cycles with hash_ready=1 → three consecutive valid results in order, result_cnt=3, no overrun. Repeat with hash_ready pulsed only on the load cycles to check the simultaneous drain+load rule.
- Reset mid-flight: count_done at cycle 0, rstb=1 at cycle 1 → no hash_valid afterwards, all outputs 0. Counter wrap with CNT_W=2: 5 results → result_cnt=1.
